main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter WORDS_PER_BLOCK, default 4, words per cache block (power of 2).
REQ-004 Parameter READ_LATENCY, default 4, cycles from read accept to first data word (min 1).
REQ-005 Parameter WRITE_LATENCY, default 1, cycles from write accept to write completion (min 1).
REQ-006 Port clk  in  1  sole clock, all logic on rising edge.
REQ-007 Port reset  in  1  synchronous, active-high reset.
REQ-008 Port req_read  in  1  block-read request from cache controller.
REQ-009 Port req_write  in  1  word-write request (write-through).
REQ-010 Port req_addr  in  ADDR_WIDTH  word address of request.
REQ-011 Port req_wdata  in  DATA_WIDTH  write data.
REQ-012 Port req_ready  out  1  responder idle, request sampled this edge.
REQ-013 Port rd_valid  out  1  rd_data carries one block word.
REQ-014 Port rd_data  out  DATA_WIDTH  returned word.
REQ-015 Port rd_word_idx  out  log2(WORDS_PER_BLOCK)  offset of returned word within block.
REQ-016 Port rd_last  out  1  final word of burst.
REQ-017 Port wr_done  out  1  one-cycle write-completion pulse.
REQ-018 Port busy  out  1  inverse of req_ready.

Function
REQ-019 Storage SHALL be 2^ADDR_WIDTH x DATA_WIDTH words, array named ram, preloadable by bench via $readmemh.
REQ-020 FSM states SHALL be IDLE, WRITE, READ_WAIT, READ_BURST; all outputs registered.
REQ-021 Request accepted only at an edge E0 where req_ready=1 and req_read or req_write=1; address/data latched at E0.
REQ-022 Simultaneous req_read and req_write SHALL accept the write only; read is not accepted and not remembered.
REQ-023 Write: IDLE->WRITE at E0; ram[addr] updated at edge E0+WRITE_LATENCY; wr_done=1 and req_ready=1 in the following cycle; wr_done lasts exactly one cycle.
REQ-024 Read: block base = req_addr with low log2(WORDS_PER_BLOCK) bits cleared; IDLE->READ_WAIT at E0.
REQ-025 Word k (k=0..WORDS_PER_BLOCK-1) SHALL be presented, ascending from offset 0, in the cycle after edge E0+READ_LATENCY+k with rd_valid=1, rd_word_idx=k.
REQ-026 Burst words SHALL be back-to-back, no gaps, no backpressure; rd_last=1 only with the final word.
REQ-027 req_ready SHALL return to 1 in the cycle after the last word; rd_valid=0 there.
REQ-028 rd_data and rd_word_idx SHALL be 0 whenever rd_valid=0.
REQ-029 Last block (base 2^ADDR_WIDTH-WORDS_PER_BLOCK) SHALL be read without address wrap or overflow.
REQ-030 A read accepted after wr_done SHALL return the newly written data.
REQ-031 Requests asserted while req_ready=0 SHALL be ignored; requester holds them until accepted.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE and next-cycle outputs req_ready=1, busy=0, rd_valid=0, rd_data=0, rd_word_idx=0, rd_last=0, wr_done=0.
REQ-033 Reset mid-burst or mid-write SHALL abort the operation; a pending write not yet committed is dropped; ram contents are never cleared by reset.
REQ-034 reset SHALL take priority over any simultaneous request.

Structure
REQ-035 Shared package cache_sys_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, WORDS_PER_BLOCK defaults and the FSM state encoding.
REQ-036 Storage SHALL be one sub-module mem_array (single-port, synchronous write, 1 read port); FSM, latency counter and word counter stay in main_mem_responder.

Verification (ram preloaded ram[i]=i, default parameters)
REQ-037 Reset held 2 cycles -> req_ready=1, busy=0, rd_valid=0, wr_done=0, rd_data=0.
REQ-038 Write addr 0x003 data 0x35 -> req_ready=0 one cycle, wr_done pulse 1 cycle, ram[0x003]=0x35.
REQ-039 Read addr 0x022 -> after 4 wait cycles rd_valid 4 consecutive cycles: 0x20,0x21,0x22,0x23, idx 0..3, rd_last on 0x23, req_ready=1 next cycle.
REQ-040 Write 0x3FF=0x5C79 then read 0x3FE -> words 0x3FC,0x3FD,0x3FE,0x5C79, no wrap to 0x000.
REQ-041 req_read=req_write=1, addr 0x008 data 0x11 -> write only, no rd_valid; subsequent read 0x008 returns 0x11 at idx 0.
REQ-042 Reset asserted after word 1 of read 0x040 -> rd_valid=0 next cycle, req_ready=1 after release, ram[0x040..0x043] unchanged.

Source files
------------

// File: rtl/cache_sys_pkg.sv
// rtl/cache_sys_pkg.sv - shared defaults and FSM encoding for the cache memory system
// Purpose: parameter defaults for the main-memory responder plus its state type.
// Contents: DEF_ADDR_WIDTH, DEF_DATA_WIDTH, DEF_WORDS_PER_BLOCK, memStateT, idxWidth().
package cache_sys_pkg;

  localparam int DEF_ADDR_WIDTH      = 10;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    READ_WAIT  = 2'd2,
    READ_BURST = 2'd3
  } memStateT;

  // Width of a word offset inside a block; never below 1 so ports stay legal.
  function automatic int idxWidth(input int wordsPerBlock);
    return (wordsPerBlock > 1) ? $clog2(wordsPerBlock) : 1;
  endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// rtl/main_mem_responder_if.sv - request/response bus between cache controller and main memory
// Purpose: groups the request handshake and the read-burst / write-done responses.
// Ports (signals): req_read, req_write, req_addr, req_wdata (controller -> memory);
//   req_ready, busy, rd_valid, rd_data, rd_word_idx, rd_last, wr_done (memory -> controller).
// Modports: master = cache controller side, slave = memory responder side.
interface main_mem_responder_if
  import cache_sys_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
);
  localparam int IDX_W = idxWidth(WORDS_PER_BLOCK);

  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  busy;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [IDX_W-1:0]      rd_word_idx;
  logic                  rd_last;
  logic                  wr_done;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  req_ready, busy, rd_valid, rd_data, rd_word_idx, rd_last, wr_done
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output req_ready, busy, rd_valid, rd_data, rd_word_idx, rd_last, wr_done
  );

endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word storage for the main-memory responder
// Purpose: 2^ADDR_WIDTH x DATA_WIDTH array, synchronous write, combinational read.
// Ports: clk, we (write enable), addr (shared read/write address), wdata, rdata.
module mem_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      ram[addr] <= wdata;
    end
  end

  // The responder registers this value, so a combinational read keeps all outputs registered.
  assign rdata = ram[addr];

endmodule

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - main-memory model answering block reads and write-through writes
// Purpose: accepts one request at a time; writes commit after WRITE_LATENCY edges and pulse
//   wr_done, reads return a whole aligned block after READ_LATENCY edges as a gapless burst.
// Ports: clk, reset (synchronous, active-high), bus (main_mem_responder_if.slave).
module main_mem_responder
  import cache_sys_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  main_mem_responder_if.slave   bus
);
  localparam int              IdxW       = idxWidth(WORDS_PER_BLOCK);
  localparam logic [7:0]      rdLastCnt  = 8'(READ_LATENCY - 1);
  localparam logic [7:0]      wrLastCnt  = 8'(WRITE_LATENCY - 1);
  localparam logic [IdxW-1:0] lastIdx    = IdxW'(WORDS_PER_BLOCK - 1);

  memStateT              state;
  logic [7:0]            latCnt;
  logic [IdxW-1:0]       wordCnt;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [DATA_WIDTH-1:0] wdataReg;

  logic                  reqReady;
  logic                  busyReg;
  logic                  rdValid;
  logic [DATA_WIDTH-1:0] rdData;
  logic [IdxW-1:0]       rdIdx;
  logic                  rdLast;
  logic                  wrDone;

  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  memWe;

  // Reads walk the block by replacing the offset bits, so the last block never carries into
  // the upper address bits and cannot wrap.
  always_comb begin
    memAddr = addrReg;
    if (state != WRITE) begin
      memAddr = {addrReg[ADDR_WIDTH-1:IdxW], wordCnt};
    end
  end

  // Reset on the commit edge drops the write.
  assign memWe = (state == WRITE) && (latCnt == wrLastCnt) && !reset;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) memArray (
    .clk   (clk),
    .we    (memWe),
    .addr  (memAddr),
    .wdata (wdataReg),
    .rdata (memRdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      latCnt   <= '0;
      wordCnt  <= '0;
      reqReady <= 1'b1;
      busyReg  <= 1'b0;
      rdValid  <= 1'b0;
      rdData   <= '0;
      rdIdx    <= '0;
      rdLast   <= 1'b0;
      wrDone   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wrDone <= 1'b0;
          // Write wins when both are asserted; the read is simply not taken.
          if (bus.req_write) begin
            state    <= WRITE;
            addrReg  <= bus.req_addr;
            wdataReg <= bus.req_wdata;
            latCnt   <= '0;
            reqReady <= 1'b0;
            busyReg  <= 1'b1;
          end else if (bus.req_read) begin
            state    <= READ_WAIT;
            addrReg  <= bus.req_addr;
            latCnt   <= '0;
            wordCnt  <= '0;
            reqReady <= 1'b0;
            busyReg  <= 1'b1;
          end
        end
        WRITE: begin
          if (latCnt == wrLastCnt) begin
            state    <= IDLE;
            wrDone   <= 1'b1;
            reqReady <= 1'b1;
            busyReg  <= 1'b0;
          end else begin
            latCnt <= latCnt + 8'd1;
          end
        end
        READ_WAIT: begin
          if (latCnt == rdLastCnt) begin
            state   <= READ_BURST;
            rdValid <= 1'b1;
            rdData  <= memRdata;
            rdIdx   <= wordCnt;
            rdLast  <= (wordCnt == lastIdx);
            wordCnt <= wordCnt + 1'b1;
          end else begin
            latCnt <= latCnt + 8'd1;
          end
        end
        READ_BURST: begin
          // rdLast being set means the final word is on the bus this cycle.
          if (rdLast) begin
            state    <= IDLE;
            rdValid  <= 1'b0;
            rdData   <= '0;
            rdIdx    <= '0;
            rdLast   <= 1'b0;
            reqReady <= 1'b1;
            busyReg  <= 1'b0;
          end else begin
            rdData  <= memRdata;
            rdIdx   <= wordCnt;
            rdLast  <= (wordCnt == lastIdx);
            wordCnt <= wordCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = reqReady;
  assign bus.busy        = busyReg;
  assign bus.rd_valid    = rdValid;
  assign bus.rd_data     = rdData;
  assign bus.rd_word_idx = rdIdx;
  assign bus.rd_last     = rdLast;
  assign bus.wr_done     = wrDone;

endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - self-checking bench for main_mem_responder
module tb_main_mem_responder;
  localparam int RL = 4;
  localparam int WL = 1;
  localparam int W  = 4;
  localparam int NW = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_mem_responder_if bus ();

  main_mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [NW];
  logic [31:0] got [W];

  logic        expOn = 1'b0;
  logic        eReady, eValid, eLast, eDone;
  logic [31:0] eData;
  logic [1:0]  eIdx;

  always @(negedge clk) begin
    if (expOn) begin
      checks++;
      if (bus.req_ready !== eReady || bus.busy !== !eReady || bus.rd_valid !== eValid ||
          bus.rd_data !== eData || bus.rd_word_idx !== eIdx || bus.rd_last !== eLast ||
          bus.wr_done !== eDone) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got rdy=%b busy=%b v=%b d=%h i=%0d l=%b wd=%b exp rdy=%b busy=%b v=%b d=%h i=%0d l=%b wd=%b",
                 $time, bus.req_ready, bus.busy, bus.rd_valid, bus.rd_data, bus.rd_word_idx,
                 bus.rd_last, bus.wr_done, eReady, !eReady, eValid, eData, eIdx, eLast, eDone);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectOut(input logic r, input logic v, input logic [31:0] d,
                           input logic [1:0] i, input logic l, input logic w);
    eReady = r; eValid = v; eData = d; eIdx = i; eLast = l; eDone = w;
  endtask

  task automatic clearReq();
    bus.req_read = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
  endtask

  // Random traffic while the responder is busy; it must all be ignored.
  task automatic garbage();
    bus.req_read  = 1'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_addr  = 10'($urandom);
    bus.req_wdata = $urandom;
  endtask

  task automatic doWrite(input logic [9:0] a, input logic [31:0] d, input logic both);
    bus.req_write = 1'b1; bus.req_read = both; bus.req_addr = a; bus.req_wdata = d;
    step(); expectOut(0, 0, 0, 0, 0, 0);
    for (int c = 1; c < WL; c++) begin
      garbage(); step(); expectOut(0, 0, 0, 0, 0, 0);
    end
    garbage(); step();
    mdl[a] = d;
    expectOut(1, 0, 0, 0, 0, 1);
    clearReq();
  endtask

  // stopAfter < W asserts reset once that word is on the bus.
  task automatic doRead(input logic [9:0] a, input int stopAfter);
    logic [9:0] base;
    base = a & ~10'(W - 1);
    bus.req_read = 1'b1; bus.req_write = 1'b0; bus.req_addr = a;
    step(); expectOut(0, 0, 0, 0, 0, 0);
    for (int c = 1; c < RL; c++) begin
      garbage(); step(); expectOut(0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < W; k++) begin
      garbage(); step();
      expectOut(0, 1, mdl[int'(base) + k], 2'(k), k == W - 1, 0);
      got[k] = bus.rd_data;
      if (k == stopAfter) begin
        clearReq();
        reset = 1'b1;
        step(); expectOut(1, 0, 0, 0, 0, 0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        reset = 1'b0;
        step(); expectOut(1, 0, 0, 0, 0, 0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        return;
      end
    end
    garbage(); step(); expectOut(1, 0, 0, 0, 0, 0);
    clearReq();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NW; i++) mdl[i] = 32'(i);
    clearReq();
    reset = 1'b1;
    step(); expOn = 1'b1; expectOut(1, 0, 0, 0, 0, 0);
    step();
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rd_data", bus.rd_data, 32'd0);
    reset = 1'b0;
    step(); expectOut(1, 0, 0, 0, 0, 0);

    // Preload ram[i] = i through the bus.
    for (int i = 0; i < NW; i++) doWrite(10'(i), 32'(i), 1'b0);

    doWrite(10'h003, 32'h35, 1'b0);
    check("wr_done_pulse", 32'(bus.wr_done), 32'd1);
    step(); expectOut(1, 0, 0, 0, 0, 0);
    check("wr_done_one_cycle", 32'(bus.wr_done), 32'd0);
    doRead(10'h003, W);
    check("read_after_write", got[3], 32'h35);

    doRead(10'h022, W);
    for (int k = 0; k < W; k++) check("block_022", got[k], 32'h20 + 32'(k));

    doWrite(10'h3FF, 32'h5C79, 1'b0);
    doRead(10'h3FE, W);
    check("last_block_w0", got[0], 32'h3FC);
    check("last_block_w1", got[1], 32'h3FD);
    check("last_block_w2", got[2], 32'h3FE);
    check("last_block_w3", got[3], 32'h5C79);

    doWrite(10'h008, 32'h11, 1'b1);
    step(); expectOut(1, 0, 0, 0, 0, 0);
    doRead(10'h008, W);
    check("rw_collision_w0", got[0], 32'h11);

    doRead(10'h040, 1);
    doRead(10'h040, W);
    for (int k = 0; k < W; k++) check("after_abort_040", got[k], 32'h40 + 32'(k));

    // Write aborted before its commit edge must leave memory untouched.
    bus.req_write = 1'b1; bus.req_addr = 10'h050; bus.req_wdata = 32'hDEAD;
    step(); expectOut(0, 0, 0, 0, 0, 0);
    clearReq(); reset = 1'b1;
    step(); expectOut(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(); expectOut(1, 0, 0, 0, 0, 0);
    doRead(10'h050, W);
    check("dropped_write", got[0], 32'h50);

    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) doWrite(10'($urandom), $urandom, $urandom_range(0, 3) == 0);
      else if (r < 8) doRead(10'($urandom), W);
      else begin
        for (int c = 0; c < $urandom_range(1, 3); c++) begin
          step(); expectOut(1, 0, 0, 0, 0, 0);
        end
      end
    end
    step(); expectOut(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    expOn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
